// File: rtl/vote_pkg.sv
// Shared types and default sizing for the vote/argmax classifier.
// Optional feature macro used by the classifier: VOTE_SAT_EN.
package vote_pkg;

   localparam int NUM_CLASSES = 9;
   localparam int PKT_W       = 8;
   localparam int COUNT_W     = 16;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      SCAN  = 2'd1,
      DONE  = 2'd2
   } vote_state_t;

endpackage

// File: rtl/vote_class_map.sv
// Packet-to-class reduction. Kept as its own block so the modulo mapping
// can later be replaced by a lookup table without touching the tally logic.
module vote_class_map #(
   parameter int NUM_CLASSES = vote_pkg::NUM_CLASSES,
   parameter int PKT_W       = vote_pkg::PKT_W,
   parameter int CLS_W       = $clog2(NUM_CLASSES)
) (
   input  logic [PKT_W-1:0] packet,
   output logic [CLS_W-1:0] class_idx
);
   import vote_pkg::*;

   // Remainder is always below NUM_CLASSES, so it fits in CLS_W bits.
   always_comb begin
      class_idx = CLS_W'(packet % PKT_W'(NUM_CLASSES));
   end

endmodule

// File: rtl/vote_argmax_classifier.sv
// Per-frame vote tally with argmax readout for the grid output stream.
// Votes accumulate per class; frame_end triggers a sequential scan for the
// largest counter (lowest index wins ties), then a one-cycle result pulse.
// Macro VOTE_SAT_EN: counters saturate and report saturation via overrun;
// without it counters wrap silently.
module vote_argmax_classifier #(
   parameter int NUM_CLASSES = vote_pkg::NUM_CLASSES,
   parameter int PKT_W       = vote_pkg::PKT_W,
   parameter int COUNT_W     = vote_pkg::COUNT_W,
   parameter int CLS_W       = $clog2(NUM_CLASSES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PKT_W-1:0]   packet_out,
   input  logic               packet_out_valid,
   input  logic               frame_end,
   input  logic               clr,
   output logic               busy,
   output logic               result_valid,
   output logic [CLS_W-1:0]   class_id,
   output logic [COUNT_W-1:0] max_count,
   output logic               overrun
);
   import vote_pkg::*;

   localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

   vote_state_t                          state_q, state_d;
   logic [NUM_CLASSES-1:0][COUNT_W-1:0]  cnt;
   logic [NUM_CLASSES-1:0]               hit;
   logic [CLS_W-1:0]                     vote_cls;
   logic [CLS_W-1:0]                     idx_q;
   logic [CLS_W-1:0]                     best_q;
   logic [COUNT_W-1:0]                   bestcnt_q;
   logic [COUNT_W-1:0]                   cur_cnt;
   logic                                 accept;
   logic                                 start;
   logic                                 scan_step;
   logic                                 finish;
   logic                                 ovr_set;

   vote_class_map #(
      .NUM_CLASSES (NUM_CLASSES),
      .PKT_W       (PKT_W),
      .CLS_W       (CLS_W)
   ) u_map (
      .packet    (packet_out),
      .class_idx (vote_cls)
   );

   assign busy    = (state_q != ACCUM);
   // Votes only land while accumulating; a same-cycle clr discards them.
   assign accept  = packet_out_valid && (state_q == ACCUM) && !clr;
   assign cur_cnt = cnt[idx_q];

   // One-hot counter select for the incoming vote.
   for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_hit
      assign hit[g] = accept && (vote_cls == CLS_W'(g));
   end

`ifdef VOTE_SAT_EN
   logic sat_hit;
   assign sat_hit = accept && (cnt[vote_cls] == '1);
   assign ovr_set = (busy && (packet_out_valid || frame_end)) || sat_hit;
`else
   assign ovr_set = busy && (packet_out_valid || frame_end);
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ACCUM;
      else     state_q <= state_d;
   end

   // Next state and per-cycle control strobes; clr overrides everything.
   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      scan_step = 1'b0;
      finish    = 1'b0;
      if (clr) begin
         state_d = ACCUM;
      end else begin
         case (state_q)
            ACCUM: begin
               if (frame_end) begin
                  state_d = SCAN;
                  start   = 1'b1;
               end
            end
            SCAN: begin
               scan_step = 1'b1;
               if (idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
               finish  = 1'b1;
               state_d = ACCUM;
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   // Per-class counters: cleared on abort and after the result is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || finish) begin
         cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_CLASSES; i++) begin
`ifdef VOTE_SAT_EN
            if (hit[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
`else
            if (hit[i]) cnt[i] <= cnt[i] + 1'b1;
`endif
         end
      end
   end

   // Argmax scan: index 0 always loads so an empty frame reports class 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= '0;
         best_q    <= '0;
         bestcnt_q <= '0;
      end else if (clr || start) begin
         idx_q     <= '0;
         best_q    <= '0;
         bestcnt_q <= '0;
      end else if (scan_step) begin
         if ((idx_q == '0) || (cur_cnt > bestcnt_q)) begin
            best_q    <= idx_q;
            bestcnt_q <= cur_cnt;
         end
         idx_q <= idx_q + 1'b1;
      end
   end

   // Result registers: pulse on leaving DONE, values held until the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_valid <= 1'b0;
         class_id     <= '0;
         max_count    <= '0;
      end else begin
         result_valid <= finish;
         if (finish) begin
            class_id  <= best_q;
            max_count <= bestcnt_q;
         end
      end
   end

   // Sticky overrun flag, cleared only by clr or reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          overrun <= 1'b0;
      else if (clr)     overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
   end

endmodule
